// File: rtl/matrix_addsub_seq_if.sv
// Operand/result bundle for the row-serial matrix add/subtract engine.
// master = operand/command side, slave = the engine itself.
interface matrix_addsub_seq_if #(
  parameter int unsigned DIM = 5,
  parameter int unsigned EW  = 8
);
  logic                    start;
  logic [1:0]              op;
  logic [DIM*DIM*EW-1:0]   mat_a;
  logic [DIM*DIM*EW-1:0]   mat_b;
  logic                    busy;
  logic                    done;
  logic [DIM*DIM*EW-1:0]   mat_out;
  logic [DIM*DIM-1:0]      ovf_mask;
  logic                    overflow;

  modport master (
    output start, op, mat_a, mat_b,
    input  busy, done, mat_out, ovf_mask, overflow
  );

  modport slave (
    input  start, op, mat_a, mat_b,
    output busy, done, mat_out, ovf_mask, overflow
  );
endinterface

// File: rtl/matrix_addsub_seq.sv
// Row-serial signed DIM x DIM matrix add/subtract with wrap or saturate, one row per clock.
// Operands are latched at start; results appear atomically with a one-cycle done pulse.
module matrix_addsub_seq #(
  parameter int unsigned DIM = 5,
  parameter int unsigned EW  = 8
) (
  input logic               clk,
  input logic               rst_n,
  matrix_addsub_seq_if.slave bus
);

  localparam int unsigned NE = DIM * DIM;
  localparam int unsigned MW = NE * EW;
  localparam int unsigned RW = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [EW-1:0] MaxVal = {1'b0, {(EW-1){1'b1}}};
  localparam logic [EW-1:0] MinVal = {1'b1, {(EW-1){1'b0}}};

  logic [0:0]    stateQ, stateD;
  logic [RW-1:0] rowQ, rowD;
  logic [MW-1:0] aQ, bQ;
  logic [1:0]    opQ;
  logic [MW-1:0] resBufQ, resNext;
  logic [NE-1:0] maskBufQ, maskNext;
  logic [MW-1:0] matOutQ;
  logic [NE-1:0] ovfMaskQ;
  logic          overflowQ;
  logic          doneQ;
  logic          lastRow;

  assign lastRow = (rowQ == RW'(DIM - 1));

  always_comb begin
    stateD = stateQ;
    rowD   = rowQ;
    unique case (stateQ)
      IDLE: begin
        if (bus.start) begin
          stateD = RUN;
          rowD   = '0;
        end
      end
      RUN: begin
        if (lastRow) begin
          stateD = IDLE;
          rowD   = '0;
        end else begin
          rowD = rowQ + RW'(1);
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // One row of DIM elements; sums kept at EW+1 bits so sub needs no negation step.
  always_comb begin
    logic [EW-1:0] aElem;
    logic [EW-1:0] bElem;
    logic [EW:0]   sum;
    logic          ovf;
    int unsigned   idx;
    resNext  = resBufQ;
    maskNext = maskBufQ;
    aElem    = '0;
    bElem    = '0;
    sum      = '0;
    ovf      = 1'b0;
    idx      = 0;
    for (int j = 0; j < DIM; j++) begin
      idx   = int'(rowQ) * DIM + j;
      aElem = aQ[idx*EW +: EW];
      bElem = bQ[idx*EW +: EW];
      if (opQ[0]) sum = {aElem[EW-1], aElem} - {bElem[EW-1], bElem};
      else        sum = {aElem[EW-1], aElem} + {bElem[EW-1], bElem};
      ovf = sum[EW] ^ sum[EW-1];
      if (ovf && opQ[1]) resNext[idx*EW +: EW] = sum[EW] ? MinVal : MaxVal;
      else               resNext[idx*EW +: EW] = sum[EW-1:0];
      maskNext[idx] = ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      rowQ      <= '0;
      aQ        <= '0;
      bQ        <= '0;
      opQ       <= '0;
      resBufQ   <= '0;
      maskBufQ  <= '0;
      matOutQ   <= '0;
      ovfMaskQ  <= '0;
      overflowQ <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      stateQ <= stateD;
      rowQ   <= rowD;
      doneQ  <= 1'b0;
      if (stateQ == IDLE && bus.start) begin
        aQ  <= bus.mat_a;
        bQ  <= bus.mat_b;
        opQ <= bus.op;
      end
      if (stateQ == RUN) begin
        resBufQ  <= resNext;
        maskBufQ <= maskNext;
        // Publish the whole matrix at once so outputs never show a partial result.
        if (lastRow) begin
          matOutQ   <= resNext;
          ovfMaskQ  <= maskNext;
          overflowQ <= |maskNext;
          doneQ     <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = (stateQ == RUN);
  assign bus.done     = doneQ;
  assign bus.mat_out  = matOutQ;
  assign bus.ovf_mask = ovfMaskQ;
  assign bus.overflow = overflowQ;

endmodule
